// File: rtl/key_pulse_gen.sv
// Push-button debouncer: turns each accepted press into a one-cycle enable pulse.
// While the key is held, it optionally generates auto-repeat pulses.
module key_pulse_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned HOLD_CYCLES     = 25000000,
  parameter int unsigned REPEAT_CYCLES   = 5000000,
  parameter bit          REPEAT_EN       = 1'b1,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1,
  parameter int unsigned CNT_W           = 25
) (
  input  logic CLK,
  input  logic CLRN,
  input  logic key_in,
  output logic pulse,
  output logic level,
  output logic held
);

  localparam logic             RelLevel = KEY_ACTIVE_LOW;
  localparam logic [CNT_W-1:0] DebLast  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RepLast  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

  typedef enum logic [1:0] {
    StIdle,
    StPressWait,
    StPressed,
    StReleaseWait
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic             sync1_q, sync2_q;
  logic             pulse_q, pulse_d;
  logic             level_q, level_d;
  logic             held_q, held_d;
  logic             key_s;
  logic [CNT_W-1:0] hcnt_last;

  assign key_s     = KEY_ACTIVE_LOW ? ~sync2_q : sync2_q;
  assign hcnt_last = held_q ? RepLast : HoldLast;

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    hcnt_d  = hcnt_q;
    pulse_d = 1'b0;
    level_d = level_q;
    held_d  = held_q;
    case (state_q)
      StIdle: begin
        if (key_s) begin
          state_d = StPressWait;
          dcnt_d  = '0;
        end
      end
      StPressWait: begin
        if (!key_s) begin
          state_d = StIdle;
        end else if (dcnt_q == DebLast) begin
          state_d = StPressed;
          pulse_d = 1'b1;
          level_d = 1'b1;
          hcnt_d  = '0;
        end else begin
          dcnt_d = dcnt_q + CntOne;
        end
      end
      StPressed: begin
        if (!key_s) begin
          state_d = StReleaseWait;
          dcnt_d  = '0;
        end else if (REPEAT_EN) begin
          if (hcnt_q == hcnt_last) begin
            pulse_d = 1'b1;
            held_d  = 1'b1;
            hcnt_d  = '0;
          end else begin
            hcnt_d = hcnt_q + CntOne;
          end
        end
      end
      StReleaseWait: begin
        if (key_s) begin
          // Release bounce: the return edge counts as a hold cycle, so the
          // repeat timing slips only by the cycles the key read as released.
          state_d = StPressed;
          if (REPEAT_EN && (hcnt_q != hcnt_last)) begin
            hcnt_d = hcnt_q + CntOne;
          end
        end else if (dcnt_q == DebLast) begin
          state_d = StIdle;
          level_d = 1'b0;
          held_d  = 1'b0;
        end else begin
          dcnt_d = dcnt_q + CntOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge CLRN) begin
    if (!CLRN) begin
      sync1_q <= RelLevel;
      sync2_q <= RelLevel;
      state_q <= StIdle;
      dcnt_q  <= '0;
      hcnt_q  <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      hcnt_q  <= hcnt_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
      held_q  <= held_d;
    end
  end

  assign pulse = pulse_q;
  assign level = level_q;
  assign held  = held_q;

endmodule

// File: tb/tb_key_pulse_gen.sv
// Bench for key_pulse_gen: expected outputs are queued per edge as the key is driven.
// One instance has auto-repeat enabled and one has it disabled.
module tb_key_pulse_gen;

  logic clk;
  logic clrn;
  logic key_in;
  logic pulse, level, held;
  logic pulse_nr, level_nr, held_nr;

  int n_checks = 0;
  int n_fail   = 0;

  // {pulse, level, held} of repeat instance, then of no-repeat instance
  logic [5:0] exp_q[$];

  key_pulse_gen #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (10),
    .REPEAT_CYCLES  (3),
    .REPEAT_EN      (1'b1),
    .KEY_ACTIVE_LOW (1'b1),
    .CNT_W          (8)
  ) dut (
    .CLK   (clk),
    .CLRN  (clrn),
    .key_in(key_in),
    .pulse (pulse),
    .level (level),
    .held  (held)
  );

  key_pulse_gen #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (10),
    .REPEAT_CYCLES  (3),
    .REPEAT_EN      (1'b0),
    .KEY_ACTIVE_LOW (1'b1),
    .CNT_W          (8)
  ) dut_nr (
    .CLK   (clk),
    .CLRN  (clrn),
    .key_in(key_in),
    .pulse (pulse_nr),
    .level (level_nr),
    .held  (held_nr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected {pulse, level, held} after edge e for a press first sampled at
  // edge k and a release first sampled at edge r; s is the repeat-timing slip.
  function automatic logic [2:0] exp_at(input int e, input int k, input int r, input int s,
                                         input bit acc, input bit rep);
    logic p, l, h;
    int   t1;
    t1 = k + 16 + s;
    if (!acc) return 3'b000;
    l = (e >= k + 6) && (e <= r + 5);
    p = (e == k + 6) ||
        (rep && (e >= t1) && (e <= r + 1) && (((e - t1) % 3) == 0));
    h = rep && (t1 <= r + 1) && (e >= t1) && (e <= r + 5);
    return {p, l, h};
  endfunction

  // Key pressed for edges k..r-1 except the released window g..g+gl-1.
  task automatic run_test(input int n, input int k, input int r, input int g, input int gl,
                          input int s, input bit acc);
    bit pressed;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pressed = (i >= k) && (i < r) && !((i >= g) && (i < g + gl));
      key_in  = ~pressed;
      exp_q.push_back({exp_at(i, k, r, s, acc, 1'b1), exp_at(i, k, r, s, acc, 1'b0)});
    end
    @(posedge clk);
    #2;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " pulse"}, 32'(pulse), 32'd0);
    check({tag, " level"}, 32'(level), 32'd0);
    check({tag, " held"}, 32'(held), 32'd0);
    check({tag, " nr pulse"}, 32'(pulse_nr), 32'd0);
    check({tag, " nr level"}, 32'(level_nr), 32'd0);
    check({tag, " nr held"}, 32'(held_nr), 32'd0);
  endtask

  int edge_idx = 0;

  always begin
    logic [5:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("e%0d pulse", edge_idx), 32'(pulse), 32'(e[5]));
      check($sformatf("e%0d level", edge_idx), 32'(level), 32'(e[4]));
      check($sformatf("e%0d held", edge_idx), 32'(held), 32'(e[3]));
      check($sformatf("e%0d nr pulse", edge_idx), 32'(pulse_nr), 32'(e[2]));
      check($sformatf("e%0d nr level", edge_idx), 32'(level_nr), 32'(e[1]));
      check($sformatf("e%0d nr held", edge_idx), 32'(held_nr), 32'(e[0]));
      edge_idx++;
    end
  end

  initial begin
    clrn   = 1'b0;
    key_in = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check_zero("reset");
    @(posedge clk);
    #2;
    clrn = 1'b1;

    // Single press held 20 cycles, then release
    run_test(32, 2, 22, -1, 0, 0, 1'b1);

    // Low glitches of 1, 2 and 3 cycles are rejected
    for (int len = 1; len <= 3; len++) begin
      run_test(12, 2, 2 + len, -1, 0, 0, 1'b0);
    end

    // Long hold: auto-repeat on one instance, single pulse on the other
    run_test(52, 2, 42, -1, 0, 0, 1'b1);

    // Two-cycle release glitch while pressed shifts repeats by two
    run_test(56, 2, 44, 10, 2, 2, 1'b1);

    // Reset during press debounce, key held through reset release
    @(negedge clk);
    key_in = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    clrn = 1'b0;
    #1;
    check_zero("rst_pw");
    repeat (2) @(posedge clk);
    #2;
    clrn = 1'b1;
    run_test(20, 0, 10, -1, 0, 0, 1'b1);

    // Reset while held and repeating clears outputs immediately
    run_test(20, 0, 1000, -1, 0, 0, 1'b1);
    #1;
    clrn = 1'b0;
    #1;
    check_zero("rst_held");
    key_in = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    clrn = 1'b1;
    run_test(10, 0, 0, -1, 0, 0, 1'b0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
